// File: rtl/mult_unit_if.sv
// Decoder/execute-stage bundle for the HI/LO multiplier: request strobes, operands,
// the mfhi/mflo selector, and the busy/readback outputs.
interface mult_unit_if #(
  parameter int WIDTH = 32
);
  logic             start_mult;
  logic             mult_sign;
  logic [WIDTH-1:0] srca;
  logic [WIDTH-1:0] srcb;
  logic             mfSrc;
  logic [WIDTH-1:0] mf_out;
  logic             mult_busy;

  modport master (
    output start_mult, mult_sign, srca, srcb, mfSrc,
    input  mf_out, mult_busy
  );

  modport slave (
    input  start_mult, mult_sign, srca, srcb, mfSrc,
    output mf_out, mult_busy
  );
endinterface

// File: rtl/mult_unit.sv
// Iterative shift-add multiplier with HI/LO result registers: magnitudes are multiplied
// one multiplier bit per cycle, and the sign is applied in a final fix-up cycle.
module mult_unit #(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       reset,
  mult_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t             state;
  logic [WIDTH-1:0]   hi;
  logic [WIDTH-1:0]   lo;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      count;
  logic               neg;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;

  // Signed operands are reduced to magnitudes; 0x80..0 negates to itself, which is
  // exactly its unsigned magnitude, so no extra bit is needed.
  assign mag_a = (bus.mult_sign & bus.srca[WIDTH-1]) ? -bus.srca : bus.srca;
  assign mag_b = (bus.mult_sign & bus.srcb[WIDTH-1]) ? -bus.srcb : bus.srcb;

  assign bus.mult_busy = (state != IDLE) | bus.start_mult;
  assign bus.mf_out    = bus.mfSrc ? lo : hi;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      hi     <= '0;
      lo     <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      count  <= '0;
      neg    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start_mult) begin
            mcand  <= {{WIDTH{1'b0}}, mag_a};
            mplier <= mag_b;
            neg    <= bus.mult_sign & (bus.srca[WIDTH-1] ^ bus.srcb[WIDTH-1]);
            acc    <= '0;
            count  <= '0;
            state  <= RUN;
          end
        end
        RUN: begin
          if (mplier[0]) begin
            acc <= acc + mcand;
          end
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count + CW'(1);
          if (count == CW'(WIDTH - 1)) begin
            state <= FIX;
          end
        end
        FIX: begin
          {hi, lo} <= neg ? -acc : acc;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mult_unit.sv
// Directed bench for mult_unit: a latency/product model checked every cycle, plus
// hand-computed HI/LO and busy-length expectations for each directed multiply.
module tb_mult_unit;
  localparam int W = 32;
  localparam int LAT = W + 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;
  bit   armed = 1'b0;

  mult_unit_if #(.WIDTH(W)) bus ();

  mult_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference: a request accepted while idle produces the full 64-bit product LAT edges later.
  logic [W-1:0]   m_hi = '0;
  logic [W-1:0]   m_lo = '0;
  logic [2*W-1:0] m_pending = '0;
  int             m_remain = 0;

  function automatic logic [2*W-1:0] product(input logic sgn, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
    logic signed [2*W-1:0] sa, sb;
    if (sgn) begin
      sa = {{W{a[W-1]}}, a};
      sb = {{W{b[W-1]}}, b};
      return sa * sb;
    end
    return {{W{1'b0}}, a} * {{W{1'b0}}, b};
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_hi = '0;
      m_lo = '0;
      m_remain = 0;
    end else if (m_remain > 0) begin
      m_remain = m_remain - 1;
      if (m_remain == 0) {m_hi, m_lo} = m_pending;
    end else if (bus.start_mult) begin
      m_pending = product(bus.mult_sign, bus.srca, bus.srcb);
      m_remain = LAT;
    end
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (armed) begin
      check("cyc_busy", {31'b0, bus.mult_busy}, {31'b0, (m_remain > 0) || bus.start_mult});
      check("cyc_mf_out", bus.mf_out, bus.mfSrc ? m_lo : m_hi);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    bus.mfSrc = 1'($urandom_range(0, 1));
  endtask

  task automatic read_hilo(input string name, input logic [W-1:0] ehi, input logic [W-1:0] elo);
    bus.mfSrc = 1'b0;
    #1;
    check({name, "_hi"}, bus.mf_out, ehi);
    bus.mfSrc = 1'b1;
    #1;
    check({name, "_lo"}, bus.mf_out, elo);
  endtask

  task automatic pulse_start(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.start_mult = 1'b1;
    bus.mult_sign = sgn;
    bus.srca = a;
    bus.srcb = b;
    #1;
    check("busy_on_strobe", {31'b0, bus.mult_busy}, 32'd1);
    tick();
    bus.start_mult = 1'b0;
    bus.srca = $urandom;
    bus.srcb = $urandom;
  endtask

  // Counts edges until busy falls; ignored_at>0 injects a second request mid-RUN.
  task automatic wait_done(input string name, input int ignored_at);
    int n = 0;
    while (bus.mult_busy && n < 100) begin
      if (ignored_at > 0 && n == ignored_at) begin
        bus.start_mult = 1'b1;
        bus.mult_sign = 1'b1;
        bus.srca = 32'h0000_0003;
        bus.srcb = 32'hFFFF_FFFF;
      end
      tick();
      bus.start_mult = 1'b0;
      n++;
    end
    check({name, "_busy_len"}, n, LAT);
  endtask

  task automatic run_mult(input string name, input logic sgn, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] ehi,
                          input logic [W-1:0] elo, input int ignored_at);
    pulse_start(sgn, a, b);
    wait_done(name, ignored_at);
    read_hilo(name, ehi, elo);
    $display("mult %s sign=%0d a=0x%08h b=0x%08h -> hi=0x%08h lo=0x%08h", name, sgn, a, b, m_hi, m_lo);
  endtask

  initial begin
    bus.start_mult = 1'b0;
    bus.mult_sign = 1'b0;
    bus.srca = '0;
    bus.srcb = '0;
    bus.mfSrc = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    armed = 1'b1;
    tick();

    check("idle_busy", {31'b0, bus.mult_busy}, 32'd0);
    read_hilo("reset", 32'h0, 32'h0);
    $display("reset idle -> hi=0x%08h lo=0x%08h", m_hi, m_lo);

    run_mult("multu_7x6", 1'b0, 32'h0000_0007, 32'h0000_0006, 32'h0000_0000, 32'h0000_002A, 0);
    run_mult("multu_max", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 0);
    run_mult("mult_m3x5", 1'b1, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 0);
    run_mult("mult_minsq", 1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 0);
    run_mult("ignore_restart", 1'b0, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780, 5);

    // Abort a multiply mid-RUN, then confirm a fresh one is unaffected.
    pulse_start(1'b0, 32'hDEAD_BEEF, 32'h0000_1234);
    repeat (10) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_busy", {31'b0, bus.mult_busy}, 32'd0);
    read_hilo("abort", 32'h0, 32'h0);
    $display("reset mid-run -> hi=0x%08h lo=0x%08h", m_hi, m_lo);
    tick();
    run_mult("after_abort", 1'b1, 32'hFFFF_FFFE, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFF2, 0);

    repeat (3) tick();
    armed = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
